// File: rtl/rob_commit.sv
// -----------------------------------------------------------------------------
// rob_commit
//   In-order reorder buffer with a single-retire commit stage. Dispatch
//   allocates entries at the tail in program order, execution units mark
//   entries done out of order, and commit retires the head once it is done.
//   Commit drives the physical register file write port and hands the old
//   physical mapping back to the rename free list, both one cycle later.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   alloc_*           dispatch request / ready / payload; alloc_tag = tail index
//   cmpl_*            completion from execution (tag + result)
//   flush             discard every in-flight entry, pointers back to 0
//   reg_wr_*          registered physical register write port
//   free_valid/phy    registered release of the previous mapping
//   count/empty/full  occupancy
// -----------------------------------------------------------------------------
module rob_commit #(
  parameter int DEPTH      = 16,
  parameter int TAG_W      = 4,
  parameter int PHY_ADDR_W = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  alloc_has_dest,
  input  logic [PHY_ADDR_W-1:0] alloc_phy_dest,
  input  logic [PHY_ADDR_W-1:0] alloc_old_phy,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  cmpl_valid,
  input  logic [TAG_W-1:0]      cmpl_tag,
  input  logic [DATA_WIDTH-1:0] cmpl_data,
  input  logic                  flush,
  output logic                  reg_wr_en,
  output logic [PHY_ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  free_valid,
  output logic [PHY_ADDR_W-1:0] free_phy,
  output logic [TAG_W:0]        count,
  output logic                  empty,
  output logic                  full
);

  typedef struct packed {
    logic                  has_dest;
    logic [PHY_ADDR_W-1:0] phy_dest;
    logic [PHY_ADDR_W-1:0] old_phy;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]     head;
  logic [TAG_W:0]     tail;
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   done_q;
  entry_t             entries [DEPTH];

  logic [TAG_W-1:0]   head_idx;
  logic [TAG_W-1:0]   tail_idx;
  logic               do_alloc;
  logic               do_commit;
  logic               cmpl_hit;
  entry_t             head_entry;

  assign head_idx   = head[TAG_W-1:0];
  assign tail_idx   = tail[TAG_W-1:0];
  assign head_entry = entries[head_idx];

  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;

  assign do_alloc  = alloc_valid && alloc_ready;
  // Commit looks only at registered done, so a completion in this cycle
  // can retire no earlier than the next one.
  assign do_commit = valid_q[head_idx] && done_q[head_idx];
  assign cmpl_hit  = cmpl_valid && valid_q[cmpl_tag];

  // Control state and output stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      free_valid  <= 1'b0;
      free_phy    <= '0;
    end else if (flush) begin
      // Address/data/free_phy hold; only the strobes are squashed.
      head       <= '0;
      tail       <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      reg_wr_en  <= 1'b0;
      free_valid <= 1'b0;
    end else begin
      reg_wr_en  <= do_commit && head_entry.has_dest && (head_entry.phy_dest != '0);
      free_valid <= do_commit && head_entry.has_dest;

      // Tail never aliases a valid entry, and head only aliases tail when
      // empty (no commit) or full (no alloc), so these updates never collide.
      if (cmpl_hit) begin
        done_q[cmpl_tag] <= 1'b1;
      end

      if (do_commit) begin
        reg_wr_addr       <= head_entry.phy_dest;
        reg_wr_data       <= head_entry.data;
        free_phy          <= head_entry.old_phy;
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head              <= head + (TAG_W+1)'(1);
      end

      if (do_alloc) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail              <= tail + (TAG_W+1)'(1);
      end
    end
  end

  // Entry payload.
  // NOTE: the payload array is deliberately not reset; nothing reads an entry
  // unless its valid/done bits (which are reset) say it was written.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entries[tail_idx].has_dest <= alloc_has_dest;
      entries[tail_idx].phy_dest <= alloc_phy_dest;
      entries[tail_idx].old_phy  <= alloc_old_phy;
    end
    if (cmpl_hit) begin
      entries[cmpl_tag].data <= cmpl_data;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// -----------------------------------------------------------------------------
// tb_rob_commit
//   Directed scenarios followed by a randomized phase, all compared every cycle
//   against a queue-based program-order model of the reorder buffer.
// -----------------------------------------------------------------------------
module tb_rob_commit;

  localparam int DEPTH      = 16;
  localparam int TAG_W      = 4;
  localparam int PHY_ADDR_W = 6;
  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic                  alloc_has_dest;
  logic [PHY_ADDR_W-1:0] alloc_phy_dest;
  logic [PHY_ADDR_W-1:0] alloc_old_phy;
  logic [TAG_W-1:0]      alloc_tag;
  logic                  cmpl_valid;
  logic [TAG_W-1:0]      cmpl_tag;
  logic [DATA_WIDTH-1:0] cmpl_data;
  logic                  flush;
  logic                  reg_wr_en;
  logic [PHY_ADDR_W-1:0] reg_wr_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic                  free_valid;
  logic [PHY_ADDR_W-1:0] free_phy;
  logic [TAG_W:0]        count;
  logic                  empty;
  logic                  full;

  rob_commit #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .PHY_ADDR_W(PHY_ADDR_W), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_dest(alloc_has_dest), .alloc_phy_dest(alloc_phy_dest),
    .alloc_old_phy(alloc_old_phy), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .flush(flush),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .free_valid(free_valid), .free_phy(free_phy),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          tag;
    bit          has_dest;
    int          phy;
    int          old;
    bit          done;
    logic [31:0] data;
  } ment_t;

  ment_t       q[$];
  int          m_tail;
  bit          e_wr_en;
  int          e_addr;
  logic [31:0] e_data;
  bit          e_fv;
  int          e_fp;

  // Observed register writes, for order checks in the directed scenarios.
  logic [37:0] wr_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_update(input bit rs, input bit fl, input bit av, input bit hd,
                              input int pd, input int op, input bit cv, input int ct,
                              input logic [31:0] cd);
    bit com;
    bit can_alloc;
    if (rs) begin
      q.delete(); m_tail = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_fv = 0; e_fp = 0;
    end else if (fl) begin
      q.delete(); m_tail = 0;
      e_wr_en = 0; e_fv = 0;
    end else begin
      com       = (q.size() > 0) && q[0].done;
      can_alloc = (q.size() < DEPTH);
      if (com) begin
        e_wr_en = q[0].has_dest && (q[0].phy != 0);
        e_addr  = q[0].phy;
        e_data  = q[0].data;
        e_fv    = q[0].has_dest;
        e_fp    = q[0].old;
      end else begin
        e_wr_en = 0;
        e_fv    = 0;
      end
      if (cv) begin
        foreach (q[i]) if (q[i].tag == ct) begin
          q[i].done = 1;
          q[i].data = cd;
        end
      end
      if (com) void'(q.pop_front());
      if (av && can_alloc) begin
        q.push_back('{tag: m_tail, has_dest: hd, phy: pd, old: op, done: 0, data: 0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic compare_all();
    check("reg_wr_en",   32'(reg_wr_en),   32'(e_wr_en));
    check("reg_wr_addr", 32'(reg_wr_addr), 32'(e_addr));
    check("reg_wr_data", reg_wr_data,      e_data);
    check("free_valid",  32'(free_valid),  32'(e_fv));
    check("free_phy",    32'(free_phy),    32'(e_fp));
    check("count",       32'(count),       32'(q.size()));
    check("empty",       32'(empty),       32'(q.size() == 0));
    check("full",        32'(full),        32'(q.size() == DEPTH));
    check("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
    check("alloc_tag",   32'(alloc_tag),   32'(m_tail));
    if (reg_wr_en === 1'b1) wr_log.push_back({reg_wr_addr, reg_wr_data});
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit av, input bit hd, input int pd, input int op,
                      input bit cv, input int ct, input logic [31:0] cd,
                      input bit fl, input bit rs);
    rst_n          = !rs;
    alloc_valid    = av;
    alloc_has_dest = hd;
    alloc_phy_dest = PHY_ADDR_W'(pd);
    alloc_old_phy  = PHY_ADDR_W'(op);
    cmpl_valid     = cv;
    cmpl_tag       = TAG_W'(ct);
    cmpl_data      = cd;
    flush          = fl;
    model_update(rs, fl, av, hd, pd, op, cv, ct, cd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit hd, input int pd, input int op);
    step(1, hd, pd, op, 0, 0, 0, 0, 0);
  endtask

  task automatic complete(input int ct, input logic [31:0] cd);
    step(0, 0, 0, 0, 1, ct, cd, 0, 0);
  endtask

  task automatic do_flush();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);

    // In-order allocate / complete / commit
    wr_log.delete();
    alloc(1, 5, 1); alloc(1, 6, 2); alloc(1, 7, 3);
    complete(0, 32'hA); complete(1, 32'hB); complete(2, 32'hC);
    idle(3);
    check("t1_nwrites", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check("t1_w0", 32'(wr_log[0]), 32'({6'd5, 32'hA}));
      check("t1_w1", 32'(wr_log[1]), 32'({6'd6, 32'hB}));
      check("t1_w2", 32'(wr_log[2]), 32'({6'd7, 32'hC}));
      check("t1_w0_addr", 32'(wr_log[0][37:32]), 32'd5);
      check("t1_w2_addr", 32'(wr_log[2][37:32]), 32'd7);
    end
    check("t1_count", 32'(count), 32'd0);

    // Out-of-order completion, in-order retire
    do_flush();
    wr_log.delete();
    alloc(1, 10, 20); alloc(1, 11, 21);
    complete(1, 32'h11);
    idle(2);
    check("t2_no_early", 32'(wr_log.size()), 32'd0);
    complete(0, 32'h10);
    check("t2_same_cycle", 32'(reg_wr_en), 32'd0);
    idle(3);
    check("t2_nwrites", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("t2_first_addr",  32'(wr_log[0][37:32]), 32'd10);
      check("t2_second_addr", 32'(wr_log[1][37:32]), 32'd11);
    end

    // Fill, full stall, wrap
    do_flush();
    for (int i = 0; i < DEPTH; i++) alloc(1, i + 1, i + 32);
    check("t3_full", 32'(full), 32'd1);
    check("t3_ready", 32'(alloc_ready), 32'd0);
    alloc(1, 40, 41);  // stalled
    for (int i = DEPTH - 1; i >= 0; i--) complete(i, 32'(i * 3 + 1));
    alloc(1, 42, 43);  // head commits, but full still stalls this allocate
    check("t3_wrap_tag", 32'(alloc_tag), 32'd0);
    alloc(1, 44, 45);
    check("t3_tag_after", 32'(alloc_tag), 32'd1);
    complete(0, 32'h55);
    idle(DEPTH + 2);
    check("t3_drained", 32'(empty), 32'd1);

    // No destination and destination 0
    do_flush();
    wr_log.delete();
    alloc(0, 9, 4);
    complete(0, 32'h99);
    idle(1);
    check("t4_nodest_fv", 32'(free_valid), 32'd0);
    check("t4_nodest_en", 32'(reg_wr_en), 32'd0);
    alloc(1, 0, 8);
    complete(1, 32'h77);
    idle(1);
    check("t4_p0_en", 32'(reg_wr_en), 32'd0);
    check("t4_p0_fv", 32'(free_valid), 32'd1);
    check("t4_p0_fp", 32'(free_phy), 32'd8);
    check("t4_nwrites", 32'(wr_log.size()), 32'd0);

    // Flush with simultaneous allocate and completion
    do_flush();
    wr_log.delete();
    alloc(1, 12, 1); alloc(1, 13, 2); alloc(1, 14, 3); alloc(1, 15, 4);
    complete(2, 32'h22); complete(3, 32'h33);
    step(1, 1, 16, 5, 1, 0, 32'h44, 1, 0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_tag0", 32'(alloc_tag), 32'd0);
    idle(4);
    check("t5_no_writes", 32'(wr_log.size()), 32'd0);

    // Completion to an invalid tag is ignored; N -> N+2 latency
    alloc(1, 20, 1); alloc(1, 21, 2);
    complete(3, 32'h3333);
    idle(2);
    check("t6_ignored", 32'(count), 32'd2);
    complete(0, 32'h1234);
    check("t6_n1", 32'(reg_wr_en), 32'd0);
    idle(1);
    check("t6_n2", 32'(reg_wr_en), 32'd1);
    check("t6_n2_data", reg_wr_data, 32'h1234);

    // Randomized traffic, including mid-operation resets and flushes
    for (int n = 0; n < 3000; n++) begin
      bit rs, fl, av, hd, cv;
      int ct;
      rs = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 59) == 0);
      av = ($urandom_range(0, 9) < 6);
      hd = ($urandom_range(0, 9) < 8);
      cv = ($urandom_range(0, 9) < 6);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) ct = q[$urandom_range(0, q.size() - 1)].tag;
      else ct = $urandom_range(0, DEPTH - 1);
      step(av, hd, $urandom_range(0, 63), $urandom_range(0, 63), cv, ct, $urandom, fl, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer plus commit stage; the writer side of the ROB-to-register-file write port (reg_wr_en / reg_wr_addr / reg_wr_data) that the 64-entry physical register file consumes.
- Dispatch allocates entries in program order and execution units mark entries complete out of order.
- Commit retires one entry per cycle in order, drives the physical register write, and returns the previous physical mapping to the rename free list.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of 2.
- TAG_W, 4, log2(DEPTH), width of the entry tag.
- PHY_ADDR_W, 6, physical register address width (64 physical regs).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_ready  out  1  entry available (combinational, = !full)
- alloc_has_dest  in  1  instruction writes a register
- alloc_phy_dest  in  PHY_ADDR_W  destination physical reg
- alloc_old_phy  in  PHY_ADDR_W  previous mapping of the architectural dest
- alloc_tag  out  TAG_W  tag of the entry being allocated (= tail index, combinational)
- cmpl_valid  in  1  execution result valid
- cmpl_tag  in  TAG_W  entry being completed
- cmpl_data  in  DATA_WIDTH  result value
- flush  in  1  discard all in-flight entries
- reg_wr_en  out  1  physical register write enable (registered)
- reg_wr_addr  out  PHY_ADDR_W  physical register write address (registered)
- reg_wr_data  out  DATA_WIDTH  physical register write data (registered)
- free_valid  out  1  old physical reg released (registered)
- free_phy  out  PHY_ADDR_W  released physical reg (registered)
- count  out  TAG_W+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Reset (rst_n low at posedge):
  - head = tail = 0 and all valid/done bits cleared.
  - reg_wr_en, reg_wr_addr, reg_wr_data, free_valid and free_phy are all 0.
  - count = 0, empty = 1, full = 0.
- Pointers: head and tail are TAG_W+1 bits wide; the MSB is the wrap bit. Empty when the pointers are equal; full when the indices are equal and the wrap bits differ. Indices wrap DEPTH-1 -> 0.
- Allocate on alloc_valid && alloc_ready:
  - Write the entry at tail with valid=1, done=0, has_dest, phy_dest and old_phy.
  - tail increments.
- Complete on cmpl_valid:
  - If entry[cmpl_tag] is valid, set done=1 and store the data.
  - If the entry is not valid, the completion is ignored.
  - Completing an already-done entry overwrites the data.
- Commit condition: entry[head] is valid && done (registered state only).
  - A completion arriving in cycle N is committable no earlier than cycle N+1.
- On commit:
  - Clear entry[head].valid and increment head.
  - Next cycle: reg_wr_en = has_dest && (phy_dest != 0), reg_wr_addr = phy_dest, reg_wr_data = data.
  - Next cycle: free_valid = has_dest, free_phy = old_phy.
- Cycles with no commit: reg_wr_en = 0 and free_valid = 0. Address and data hold their last values.
- Throughput: at most one commit per cycle.
- Allocate and commit in the same cycle are both allowed; count stays unchanged.
- alloc_ready depends only on full. When full, allocation stalls even if a commit frees an entry that cycle.
- A completion targeting head in the same cycle as that head commits is impossible, because the head is not done yet.
- flush has priority over allocate, complete and commit in the same cycle:
  - Clear all valid bits and set head = tail = 0.
  - Next cycle: reg_wr_en = 0 and free_valid = 0.
  - A commit already registered in the output stage is still presented in the cycle flush is asserted.
- Reset mid-operation discards all entries with no writes issued.
- Phys reg 0 is never written; free_valid still reports it when has_dest = 1.

Test Plan:
- Reset, then allocate 3 entries (dest 5/6/7, old 1/2/3) and complete tags 0, 1, 2 with 0xA, 0xB, 0xC -> reg writes (5,0xA), (6,0xB), (7,0xC) on consecutive cycles, frees 1, 2, 3; count returns to 0.
- Allocate tags 0 and 1, complete tag 1 first and then tag 0 two cycles later -> no write until tag 0 is done; writes occur in order tag 0, then tag 1.
- Fill 16 entries -> full = 1, alloc_ready = 0. Complete all, commit one, allocate -> the new tag is 0 (wrap) and count stays correct.
- Allocate with has_dest = 0, then complete -> entry retires, reg_wr_en = 0, free_valid = 0. Allocate with phy_dest = 0 and has_dest = 1 -> reg_wr_en = 0, free_valid = 1.
- Allocate 4 entries with 2 completed and assert flush in the same cycle as an allocate and a completion -> empty = 1 next cycle, no subsequent writes, next alloc_tag = 0.
- Complete tag 3 while only tags 0-1 are valid -> ignored. Complete a tag in cycle N -> its commit write appears at cycle N+2 at the earliest.
